// File: rtl/pwm_regulator_mc.sv
// pwm_regulator_mc: multi-channel, feedback-regulated PWM generator.
// A shared free-running ramp is phase-staggered per channel and compared
// against a per-channel duty register. On every regulation tick each duty is
// nudged by its fb comparator, clamped to [DUTY_MIN, ceiling]. The ceiling
// itself climbs from DUTY_MIN to DUTY_MAX during soft-start. A fault forces
// the gates off and latches until enable is dropped.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   enable             run request (level)
//   fault              overcurrent/overvoltage, sampled every clock
//   fb[CHANNELS]       1 = output above target, decrease duty
//   pwm[CHANNELS]      registered gate outputs
//   en                 registered power-stage enable
//   duty_bus           current duty per channel, ch i at [i*WIDTH +: WIDTH]
//   state              00 IDLE, 01 SOFTSTART, 10 REGULATE, 11 FAULT
module pwm_regulator_mc #(
  parameter int unsigned WIDTH         = 11,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned UPDATE_PERIOD = 15000,
  parameter int unsigned STEP          = 1,
  parameter int unsigned DUTY_MIN      = 0,
  parameter int unsigned DUTY_MAX      = 1536
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         fault,
  input  logic [CHANNELS-1:0]          fb,
  output logic [CHANNELS-1:0]          pwm,
  output logic                         en,
  output logic [CHANNELS*WIDTH-1:0]    duty_bus,
  output logic [1:0]                   state
);

  localparam int unsigned WW = WIDTH + 1;
  localparam int unsigned PH = (2 ** WIDTH) / CHANNELS;
  localparam int unsigned TW = $clog2(UPDATE_PERIOD);

  localparam logic [WIDTH:0]   STEP_X    = WW'(STEP);
  localparam logic [WIDTH:0]   MIN_X     = WW'(DUTY_MIN);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(DUTY_MIN);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(DUTY_MAX);
  localparam logic [TW-1:0]    TICK_LAST = TW'(UPDATE_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SOFT  = 2'b01,
    S_REG   = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     ramp_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [WIDTH-1:0]     ceil_q, ceil_d, ceil_new;
  logic [WIDTH-1:0]     duty_q [CHANNELS];
  logic [WIDTH-1:0]     duty_d [CHANNELS];
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic                 en_q, en_d;
  logic                 tick;
  logic                 run;

  // One regulation step in WIDTH+1 bits: down clamps at DUTY_MIN, up at lim.
  function automatic logic [WIDTH-1:0] step_duty(input logic [WIDTH-1:0] d,
                                                 input logic             down,
                                                 input logic [WIDTH-1:0] lim);
    logic [WIDTH:0] x;
    if (down) begin
      if ({1'b0, d} < (MIN_X + STEP_X)) return MIN_W;
      x = {1'b0, d} - STEP_X;
    end else begin
      x = {1'b0, d} + STEP_X;
      if (x > {1'b0, lim}) return lim;
    end
    return WIDTH'(x);
  endfunction

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign ceil_new = step_duty(ceil_q, 1'b0, MAX_W);

  // Next-state, duty/ceiling update and gate outputs.
  always_comb begin
    state_d = state_q;
    ceil_d  = ceil_q;
    for (int i = 0; i < int'(CHANNELS); i++) duty_d[i] = duty_q[i];

    case (state_q)
      S_IDLE: begin
        ceil_d = MIN_W;
        for (int i = 0; i < int'(CHANNELS); i++) duty_d[i] = MIN_W;
        if (enable) state_d = S_SOFT;
      end
      S_SOFT: begin
        // Dropping enable on a tick clock suppresses that tick's update.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          ceil_d = ceil_new;
          for (int i = 0; i < int'(CHANNELS); i++)
            duty_d[i] = step_duty(duty_q[i], fb[i], ceil_new);
          if (ceil_new == MAX_W) state_d = S_REG;
        end
      end
      S_REG: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          for (int i = 0; i < int'(CHANNELS); i++)
            duty_d[i] = step_duty(duty_q[i], fb[i], ceil_q);
        end
      end
      S_FAULT: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Fault overrides every other transition and clears the regulation state.
    if (fault) begin
      state_d = S_FAULT;
      ceil_d  = MIN_W;
      for (int i = 0; i < int'(CHANNELS); i++) duty_d[i] = MIN_W;
    end

    // Gates follow the next state so pwm and en drop together.
    run  = (state_d == S_SOFT) || (state_d == S_REG);
    en_d = run;
    for (int i = 0; i < int'(CHANNELS); i++)
      pwm_d[i] = run && (WIDTH'(ramp_q + WIDTH'(i * PH)) < duty_q[i]);
  end

  // State, counters and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ramp_q     <= '0;
      tick_cnt_q <= '0;
      ceil_q     <= MIN_W;
      for (int i = 0; i < int'(CHANNELS); i++) duty_q[i] <= MIN_W;
      pwm_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramp_q     <= ramp_q + WIDTH'(1);
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      ceil_q     <= ceil_d;
      for (int i = 0; i < int'(CHANNELS); i++) duty_q[i] <= duty_d[i];
      pwm_q      <= pwm_d;
      en_q       <= en_d;
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_duty_bus
    assign duty_bus[g*WIDTH +: WIDTH] = duty_q[g];
  end

  assign pwm   = pwm_q;
  assign en    = en_q;
  assign state = state_q;

endmodule

// File: tb/tb_pwm_regulator_mc.sv
// Testbench for pwm_regulator_mc with WIDTH=4, STEP=2, DUTY_MIN=2, DUTY_MAX=12,
// UPDATE_PERIOD=4; a second single-channel instance uses DUTY_MAX=15.
module tb_pwm_regulator_mc;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fault = 1'b0;
  logic [1:0] fb = 2'b00;
  logic [1:0] pwm;
  logic       en;
  logic [7:0] duty_bus;
  logic [1:0] state;

  logic       enable2 = 1'b0;
  logic       fault2 = 1'b0;
  logic [0:0] fb2 = 1'b0;
  logic [0:0] pwm2;
  logic       en2;
  logic [3:0] duty_bus2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  pwm_regulator_mc #(
    .WIDTH(4), .CHANNELS(2), .UPDATE_PERIOD(4), .STEP(2), .DUTY_MIN(2), .DUTY_MAX(12)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .fault(fault), .fb(fb),
    .pwm(pwm), .en(en), .duty_bus(duty_bus), .state(state)
  );

  pwm_regulator_mc #(
    .WIDTH(4), .CHANNELS(1), .UPDATE_PERIOD(4), .STEP(2), .DUTY_MIN(2), .DUTY_MAX(15)
  ) dut1 (
    .clock(clock), .reset(reset), .enable(enable2), .fault(fault2), .fb(fb2),
    .pwm(pwm2), .en(en2), .duty_bus(duty_bus2), .state(state2)
  );

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_duty_change(input string tag);
    logic [7:0] prev;
    int n;
    prev = duty_bus;
    n = 0;
    while (duty_bus === prev && n < 8) begin
      step();
      n++;
    end
    if (duty_bus === prev) begin
      checks++; errors++;
      $display("FAIL %s timeout: duty_bus stuck at %h", tag, duty_bus);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; fault = 1'b0; fb = 2'b00;
    repeat (3) step();
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if ({pwm, en, duty_bus, state} !== {2'b00, 1'b0, 8'h22, 2'b00}) begin
        errors++;
        $display("FAIL idle cyc%0d: pwm=%b en=%b duty=%h state=%b, need 00 0 22 00",
                 i, pwm, en, duty_bus, state);
      end
    end
  endtask

  task automatic test_softstart();
    logic [3:0] kv;
    enable = 1'b1; fb = 2'b00;
    step();
    checks++;
    if ({state, en, duty_bus} !== {2'b01, 1'b1, 8'h22}) begin
      errors++;
      $display("FAIL ss_enter: state=%b en=%b duty=%h, need 01 1 22", state, en, duty_bus);
    end
    for (int k = 4; k <= 12; k += 2) begin
      wait_duty_change("ss_step");
      kv = 4'(k);
      checks++;
      if (duty_bus !== {kv, kv} || state !== ((k == 12) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL ss_duty k=%0d: duty=%h state=%b, need %h%h", k, duty_bus, state, kv, kv);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (duty_bus !== 8'hCC || state !== 2'b10 || en !== 1'b1) begin
        errors++;
        $display("FAIL ss_saturate: duty=%h state=%b en=%b, need CC 10 1", duty_bus, state, en);
      end
    end
  endtask

  task automatic test_regulate();
    int c0, c1;
    fb = 2'b01;
    for (int k = 10; k >= 2; k -= 2) begin
      wait_duty_change("reg_step");
      checks++;
      if (duty_bus !== {4'd12, 4'(k)}) begin
        errors++;
        $display("FAIL reg_duty: duty=%h, need c%h", duty_bus, 4'(k));
      end
    end
    repeat (8) step();
    checks++;
    if (duty_bus !== 8'hC2) begin
      errors++;
      $display("FAIL reg_clamp: duty=%h, need C2", duty_bus);
    end
    c0 = 0; c1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      c0 += int'(pwm[0]);
      c1 += int'(pwm[1]);
    end
    checks++;
    if (c0 != 2) begin
      errors++;
      $display("FAIL reg_pwm0_high: got %0d of 16, need 2", c0);
    end
    checks++;
    if (c1 != 12) begin
      errors++;
      $display("FAIL reg_pwm1_high: got %0d of 16, need 12", c1);
    end
  endtask

  task automatic test_phase();
    logic [1:0] fbs [4] = '{2'b11, 2'b10, 2'b10, 2'b00};
    logic [7:0] exp [4] = '{8'hA2, 8'h84, 8'h66, 8'h88};
    logic p0, p1;
    bit found;
    int n;
    for (int i = 0; i < 4; i++) begin
      fb = fbs[i];
      wait_duty_change("ph_step");
      checks++;
      if (duty_bus !== exp[i]) begin
        errors++;
        $display("FAIL ph_duty%0d: duty=%h, need %h", i, duty_bus, exp[i]);
      end
    end
    // pwm[0] rising edge: ramp wraps to 0, visible one clock later.
    p0 = pwm[0]; found = 0; n = 0;
    while (!found && n < 40) begin
      step(); n++;
      if (!p0 && pwm[0]) found = 1;
      p0 = pwm[0];
    end
    checks++;
    if (!found || (cyc % 16) != 1) begin
      errors++;
      $display("FAIL ph_rise0: found=%0d cyc%%16=%0d, need 1 1", found, cyc % 16);
    end
    p1 = pwm[1]; found = 0; n = 0;
    while (!found && n < 20) begin
      step(); n++;
      if (!p1 && pwm[1]) found = 1;
      p1 = pwm[1];
    end
    checks++;
    if (!found || n != 8) begin
      errors++;
      $display("FAIL ph_rise1_delay: found=%0d delay=%0d, need 1 8", found, n);
    end
    p0 = pwm[0]; found = 0; n = 0;
    while (!found && n < 20) begin
      step(); n++;
      if (!p0 && pwm[0]) found = 1;
      p0 = pwm[0];
    end
    checks++;
    if (!found || n != 8) begin
      errors++;
      $display("FAIL ph_rise0_again: found=%0d delay=%0d, need 1 8", found, n);
    end
  endtask

  task automatic test_fault();
    fault = 1'b1;
    step();
    fault = 1'b0;
    checks++;
    if ({pwm, en, state, duty_bus} !== {2'b00, 1'b0, 2'b11, 8'h22}) begin
      errors++;
      $display("FAIL fault_hit: pwm=%b en=%b state=%b duty=%h, need 00 0 11 22",
               pwm, en, state, duty_bus);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({pwm, en, state} !== {2'b00, 1'b0, 2'b11}) begin
        errors++;
        $display("FAIL fault_latch: pwm=%b en=%b state=%b, need 00 0 11", pwm, en, state);
      end
    end
    enable = 1'b0;
    step();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL fault_exit: state=%b, need 00", state);
    end
    enable = 1'b1; fb = 2'b00;
    step();
    checks++;
    if (state !== 2'b01 || duty_bus !== 8'h22) begin
      errors++;
      $display("FAIL fault_restart: state=%b duty=%h, need 01 22", state, duty_bus);
    end
    wait_duty_change("fault_ss");
    checks++;
    if (duty_bus !== 8'h44) begin
      errors++;
      $display("FAIL fault_ss_first: duty=%h, need 44", duty_bus);
    end
  endtask

  task automatic test_corners();
    int c;
    int n;
    // A tick was just applied; the next one lands four clocks later.
    repeat (3) step();
    enable = 1'b0;
    step();
    checks++;
    if ({state, duty_bus, en, pwm} !== {2'b00, 8'h44, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL tick_vs_disable: state=%b duty=%h en=%b pwm=%b, need 00 44 0 00",
               state, duty_bus, en, pwm);
    end
    step();
    checks++;
    if (duty_bus !== 8'h22) begin
      errors++;
      $display("FAIL idle_clear: duty=%h, need 22", duty_bus);
    end

    // Single channel, DUTY_MAX=15.
    enable2 = 1'b1;
    n = 0;
    while (state2 !== 2'b10 && n < 60) begin
      step(); n++;
    end
    checks++;
    if (state2 !== 2'b10 || duty_bus2 !== 4'd15) begin
      errors++;
      $display("FAIL ch1_reach: state=%b duty=%h, need 10 f", state2, duty_bus2);
    end
    c = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      c += int'(pwm2[0]);
    end
    checks++;
    if (c != 15) begin
      errors++;
      $display("FAIL ch1_high: got %0d of 16, need 15", c);
    end

    // Reset asserted while regulating.
    enable = 1'b1; fb = 2'b00;
    n = 0;
    while (state !== 2'b10 && n < 60) begin
      step(); n++;
    end
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL rst_reach_reg: state=%b, need 10", state);
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    checks++;
    if ({pwm, en, duty_bus, state} !== {2'b00, 1'b0, 8'h22, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid: pwm=%b en=%b duty=%h state=%b, need 00 0 22 00",
               pwm, en, duty_bus, state);
    end
    checks++;
    if ({pwm2, en2, duty_bus2, state2} !== {1'b0, 1'b0, 4'h2, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid_ch1: pwm=%b en=%b duty=%h state=%b, need 0 0 2 00",
               pwm2, en2, duty_bus2, state2);
    end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_softstart();
    test_regulate();
    test_phase();
    test_fault();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
